// File: rtl/fetch_queue_unit_if.sv
// Instruction-cache request channel between the fetch stage and the icache.
// master: fetch side (issues requests), slave: cache side (returns data).
interface fetch_queue_unit_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport master (output imemREN, output imemaddr, input ihit, input imemload);
    modport slave  (input imemREN, input imemaddr, output ihit, output imemload);
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue of {pc, npc, instr}.
// Owns the fetch PC, issues icache reads, hands words to decode via valid/ready,
// flushes on execute redirects and stops permanently on halt.
// Optional macro FETCH_JUMP_PREDECODE_EN: follow J/JAL targets at push time.
module fetch_queue_unit #(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          DEPTH   = 4,
    localparam int         CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    fetch_queue_unit_if.master  cache,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                halt_req,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [31:0]         instr_pc,
    output logic [31:0]         instr_npc,
    output logic [CNT_W-1:0]    occupancy,
    output logic                halted
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t             r_state;
    logic [31:0]        r_fetch_pc;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_npc   [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];

    logic               w_ren;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_seq_pc;
    logic [1:0]         w_unused_rpc;

    assign w_unused_rpc = redirect_pc[1:0];

    assign w_ren       = (r_state == RUN) && (r_count < CNT_W'(DEPTH)) && !redirect_valid;
    assign w_push      = cache.ihit && w_ren;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign w_pc_plus4  = r_fetch_pc + 32'd4;

    assign cache.imemREN  = w_ren;
    assign cache.imemaddr = r_fetch_pc;
    assign instr_valid    = (r_count != '0);
    assign instr          = r_mem_instr[r_rd_ptr];
    assign instr_pc       = r_mem_pc[r_rd_ptr];
    assign instr_npc      = r_mem_npc[r_rd_ptr];
    assign occupancy      = r_count;
    assign halted         = (r_state == HALTED);

    // Next sequential fetch PC after a push (optionally following direct jumps)
    always_comb begin
        w_seq_pc = w_pc_plus4;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (cache.imemload[31:26] == 6'b000010 || cache.imemload[31:26] == 6'b000011)
            w_seq_pc = {w_pc_plus4[31:28], cache.imemload[25:0], 2'b00};
`else
`endif
    end

    // Fetch FSM and fetch PC; redirect beats both halt and push
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= RUN;
            r_fetch_pc <= PC_INIT;
        end else begin
            if (redirect_valid)
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_push)
                r_fetch_pc <= w_seq_pc;

            if (r_state == RUN && halt_req && !redirect_valid)
                r_state <= HALTED;
        end
    end

    // Queue storage, pointers and occupancy; redirect flushes everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_npc[i]   <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
                r_mem_npc[r_wr_ptr]   <= w_pc_plus4;
                r_mem_instr[r_wr_ptr] <= cache.imemload;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the fetch stage.
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ins;
    } entry_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic             halt_req = 1'b0;
    logic             instr_ready = 1'b0;
    logic             instr_valid;
    logic [31:0]      instr, instr_pc, instr_npc;
    logic [CNT_W-1:0] occupancy;
    logic             halted;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    entry_t      m_q[$];

    fetch_queue_unit_if ifc ();

    fetch_queue_unit #(.PC_INIT(32'h0), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .cache(ifc.master),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_npc(instr_npc),
        .occupancy(occupancy), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input bit rst, input bit hit, input logic [31:0] load,
                         input bit rdy, input bit redir, input logic [31:0] rpc,
                         input bit hlt);
        RST = rst; ifc.ihit = hit; ifc.imemload = load; instr_ready = rdy;
        redirect_valid = redir; redirect_pc = rpc; halt_req = hlt;
        #1;
    endtask

    // Advance one clock; the model applies the fetch-stage rules to the inputs held.
    task automatic tick();
        bit ren;
        logic [31:0] nxt;
        @(posedge CLK);
        if (RST) begin
            m_pc = 32'h0; m_halt = 0; m_q.delete();
        end else begin
            ren = !m_halt && (m_q.size() < DEPTH) && !redirect_valid;
            if (redirect_valid) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
                if (ren && ifc.ihit) begin
                    m_q.push_back('{pc: m_pc, npc: m_pc + 32'd4, ins: ifc.imemload});
                    nxt = m_pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
                    if (ifc.imemload[31:27] == 5'b00001)
                        nxt = {nxt[31:28], ifc.imemload[25:0], 2'b00};
`endif
                    m_pc = nxt;
                end
                if (halt_req) m_halt = 1;
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h2000_0001, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (ifc.imemREN !== 1'b1) begin n_errors++; $display("FAIL reset_ren got %0b want 1", ifc.imemREN); end
        n_checks++; if (ifc.imemaddr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got %h want 0", ifc.imemaddr); end
        n_checks++; if (instr_valid !== 1'b0 || occupancy !== '0) begin n_errors++; $display("FAIL reset_queue valid %0b occ %0d want 0 0", instr_valid, occupancy); end
        n_checks++; if ({instr, instr_pc, instr_npc} !== '0 || halted !== 1'b0) begin n_errors++; $display("FAIL reset_head got %h %h %h halted %0b want zeros", instr, instr_pc, instr_npc, halted); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 1, 32'h2000_0000 | k, 0, 0, 0, 0);
            n_checks++; if (ifc.imemaddr !== 32'(4 * k)) begin n_errors++; $display("FAIL fill_addr got %h want %h", ifc.imemaddr, 4 * k); end
            tick();
        end
        drive(0, 1, 32'h2000_00ff, 0, 0, 0, 0);
        n_checks++; if (occupancy !== CNT_W'(DEPTH) || ifc.imemREN !== 1'b0) begin n_errors++; $display("FAIL fill_full occ %0d ren %0b want 4 0", occupancy, ifc.imemREN); end
        n_checks++; if (instr_pc !== 32'h0 || instr_npc !== 32'h4 || instr !== 32'h2000_0000) begin n_errors++; $display("FAIL fill_head got %h %h %h want 0 4 20000000", instr_pc, instr_npc, instr); end
        tick();
        n_checks++; if (occupancy !== CNT_W'(DEPTH)) begin n_errors++; $display("FAIL fill_nopush occ %0d want 4", occupancy); end
    endtask

    task automatic test_pop_one();
        drive(0, 1, 32'h2000_0055, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (instr_pc !== 32'h4 || occupancy !== 3) begin n_errors++; $display("FAIL pop_head pc %h occ %0d want 4 3", instr_pc, occupancy); end
        n_checks++; if (ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h10) begin n_errors++; $display("FAIL pop_refill ren %0b addr %h want 1 10", ifc.imemREN, ifc.imemaddr); end
    endtask

    task automatic test_stream();
        logic [31:0] last;
        drive(0, 0, 0, 1, 0, 0, 0);
        tick();
        last = instr_pc - 32'd4;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            drive(0, 1, 32'h2400_0000 | k, 1, 0, 0, 0);
            n_checks++; if (instr_pc !== last + 32'd4 || occupancy !== 2) begin n_errors++; $display("FAIL stream pc %h occ %0d want %h 2", instr_pc, occupancy, last + 32'd4); end
            last = instr_pc;
            tick();
        end
    endtask

    task automatic test_redirect();
        drive(0, 1, 32'h2000_0000, 1, 1, 32'h103, 0);
        n_checks++; if (ifc.imemREN !== 1'b0) begin n_errors++; $display("FAIL redir_ren got %0b want 0", ifc.imemREN); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (occupancy !== '0 || instr_valid !== 1'b0 || ifc.imemaddr !== 32'h100) begin n_errors++; $display("FAIL redir_flush occ %0d valid %0b addr %h want 0 0 100", occupancy, instr_valid, ifc.imemaddr); end
    endtask

    task automatic test_predecode();
        drive(0, 0, 0, 0, 1, 32'h20, 0);
        tick();
        drive(0, 1, 32'h0800_0040, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_JUMP_PREDECODE_EN
        n_checks++; if (ifc.imemaddr !== 32'h100) begin n_errors++; $display("FAIL jump_addr got %h want 100", ifc.imemaddr); end
`else
        n_checks++; if (ifc.imemaddr !== 32'h24) begin n_errors++; $display("FAIL jump_addr got %h want 24", ifc.imemaddr); end
`endif
        n_checks++; if (instr_pc !== 32'h20 || instr_npc !== 32'h24) begin n_errors++; $display("FAIL jump_entry pc %h npc %h want 20 24", instr_pc, instr_npc); end
    endtask

    task automatic test_random();
        bit exp_ren;
        for (int c = 0; c < 600; c++) begin
            drive(0, ($urandom_range(0, 9) < 6), $urandom(), $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0), $urandom(), 0);
            exp_ren = !m_halt && (m_q.size() < DEPTH) && !redirect_valid;
            n_checks++; if (ifc.imemREN !== exp_ren || ifc.imemaddr !== m_pc) begin n_errors++; $display("FAIL rand_req cyc %0d ren %0b addr %h want %0b %h", c, ifc.imemREN, ifc.imemaddr, exp_ren, m_pc); end
            n_checks++; if (occupancy !== CNT_W'(m_q.size()) || instr_valid !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rand_occ cyc %0d occ %0d want %0d", c, occupancy, m_q.size()); end
            if (m_q.size() != 0) begin
                n_checks++; if (instr_pc !== m_q[0].pc || instr_npc !== m_q[0].npc || instr !== m_q[0].ins) begin n_errors++; $display("FAIL rand_head cyc %0d got %h %h %h want %h %h %h", c, instr_pc, instr_npc, instr, m_q[0].pc, m_q[0].npc, m_q[0].ins); end
            end
            tick();
        end
    endtask

    task automatic test_halt();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h2000_0010 | k, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 1);
        tick();
        drive(0, 1, 0, 1, 0, 0, 0);
        n_checks++; if (halted !== 1'b1 || ifc.imemREN !== 1'b0 || occupancy !== 2) begin n_errors++; $display("FAIL halt_enter halted %0b ren %0b occ %0d want 1 0 2", halted, ifc.imemREN, occupancy); end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 32'h2000_0000, 1, 0, 0, 0);
            n_checks++; if (occupancy !== '0 || ifc.imemREN !== 1'b0) begin n_errors++; $display("FAIL halt_drained occ %0d ren %0b want 0 0", occupancy, ifc.imemREN); end
            tick();
        end
        drive(0, 1, 0, 0, 1, 32'h204, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        n_checks++; if (ifc.imemaddr !== 32'h204 || ifc.imemREN !== 1'b0 || halted !== 1'b1) begin n_errors++; $display("FAIL halt_redir addr %h ren %0b halted %0b want 204 0 1", ifc.imemaddr, ifc.imemREN, halted); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 32'h0800_0040, 1, 1, 32'h300, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (halted !== 1'b0 || ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h0 || occupancy !== '0) begin n_errors++; $display("FAIL reset_mid halted %0b ren %0b addr %h occ %0d want 0 1 0 0", halted, ifc.imemREN, ifc.imemaddr, occupancy); end
    endtask

    initial begin
        ifc.ihit = 1'b0;
        ifc.imemload = '0;
        m_pc = '0; m_halt = 0;
        @(negedge CLK);
        test_reset();
        test_fill();
        test_pop_one();
        test_stream();
        test_redirect();
        test_predecode();
        test_random();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
